// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and widths for the fetch/data RAM arbiter
// Purpose: arbiter FSM state, request kinds and counter widths used by
//          mem_arbiter and arb_lat_cnt.
// Ports:   none (package).
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DATA_BUSY = 2'd1,
      INST_BUSY = 2'd2,
      DONE      = 2'd3
   } arb_state_t;

   typedef enum logic [1:0] {
      NONE  = 2'd0,
      FETCH = 2'd1,
      LOAD  = 2'd2,
      STORE = 2'd3
   } req_kind_t;

   // The counter must hold the largest legal latency, so it is sized for
   // the top of the MEM_LAT range rather than one particular instance.
   localparam int MEM_LAT_MAX = 7;
   localparam int CNT_W       = $clog2(MEM_LAT_MAX + 1);

   // Holds the largest legal STARVE_MAX (15).
   localparam int STARVE_W    = 4;

endpackage

// File: rtl/arb_lat_cnt.sv
// rtl/arb_lat_cnt.sv - loadable down-counter timing one RAM access
// Purpose: loads LOAD_VAL when an access is granted and counts down once per
//          cycle; done is high in the last busy cycle, i.e. the cycle whose
//          closing edge brings the count to zero.
// Ports:   clk, rst (async, active-high), load (grant strobe),
//          done (count is 1, expires at the next edge).
module arb_lat_cnt
   import arb_pkg::*;
#(
   parameter int LOAD_VAL = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic done
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= CNT_W'(LOAD_VAL);
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == CNT_W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for the shared single-port RAM
// Purpose: grants one access at a time to the fetch or memory stage, drives
//          the registered RAM command, returns read data with a one-cycle
//          valid pulse and produces the pipeline stall signals. Data beats
//          fetch, except that fetch is forced through after STARVE_MAX
//          consecutive data grants while it waits.
// Ports:   clk, rst (async, active-high)
//          if_req/if_addr, flush          - fetch request, fetch discard
//          mem_rd/mem_wr/mem_addr/mem_wdata - data request
//          if_valid/if_rdata, mem_valid/mem_rdata - completions
//          ram_en/ram_we/ram_addr/ram_wdata - registered RAM command
//          ram_rdata                       - RAM read data, MEM_LAT after ram_en
//          stall_pc, stall_mem             - combinational stage stalls
module mem_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              flush,
   input  logic              mem_rd,
   input  logic              mem_wr,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_rdata,
   output logic              mem_valid,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              stall_pc,
   output logic              stall_mem
);

   arb_state_t          state;
   req_kind_t           kind;
   logic [STARVE_W-1:0] starve_cnt;
   logic                flush_pend;

   logic mem_req;
   logic starved;
   logic data_win;
   logic inst_win;
   logic grant;
   logic cnt_done;
   logic in_done;

   assign mem_req  = mem_rd | mem_wr;
   assign starved  = if_req && (starve_cnt == STARVE_W'(STARVE_MAX));
   assign data_win = (state == IDLE) && mem_req && !starved;
   // A starved fetch blocked by flush leaves the cycle with no grant at all.
   assign inst_win = (state == IDLE) && !data_win && if_req && !flush;
   assign grant    = data_win | inst_win;

   arb_lat_cnt #(
      .LOAD_VAL (MEM_LAT)
   ) u_lat_cnt (
      .clk  (clk),
      .rst  (rst),
      .load (grant),
      .done (cnt_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         kind       <= NONE;
         starve_cnt <= '0;
         flush_pend <= 1'b0;
         ram_en     <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
      end else begin
         ram_en <= 1'b0;
         ram_we <= 1'b0;
         case (state)
            IDLE: begin
               if (data_win) begin
                  state     <= DATA_BUSY;
                  kind      <= mem_wr ? STORE : LOAD;
                  ram_en    <= 1'b1;
                  ram_we    <= mem_wr;
                  ram_addr  <= mem_addr;
                  ram_wdata <= mem_wdata;
               end else if (inst_win) begin
                  state    <= INST_BUSY;
                  kind     <= FETCH;
                  ram_en   <= 1'b1;
                  ram_addr <= if_addr;
               end
               if (!if_req || inst_win) begin
                  starve_cnt <= '0;
               end else if (data_win && starve_cnt != STARVE_W'(STARVE_MAX)) begin
                  starve_cnt <= starve_cnt + 1'b1;
               end
            end
            DATA_BUSY: begin
               if (cnt_done) state <= DONE;
            end
            INST_BUSY: begin
               // The RAM read is left to finish; only its result is dropped.
               if (flush) flush_pend <= 1'b1;
               if (cnt_done) state <= DONE;
            end
            DONE: begin
               state      <= IDLE;
               kind       <= NONE;
               flush_pend <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The counter has expired in DONE, so ram_rdata is the granted word.
   assign in_done   = (state == DONE);
   assign if_valid  = in_done && (kind == FETCH) && !flush_pend && !flush;
   assign mem_valid = in_done && ((kind == LOAD) || (kind == STORE));
   assign if_rdata  = if_valid ? ram_rdata : '0;
   assign mem_rdata = (mem_valid && kind == LOAD) ? ram_rdata : '0;

   assign stall_pc  = if_req & ~if_valid;
   assign stall_mem = mem_req & ~mem_valid;

   // Requesters must hold their request until completion; a fetch may be
   // withdrawn once it has been flushed.
   a_mem_hold: assert property (@(posedge clk) disable iff (rst)
      (mem_req && !mem_valid) |=> mem_req);
   a_if_hold: assert property (@(posedge clk) disable iff (rst)
      (if_req && !if_valid && !flush && !flush_pend) |=> if_req);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

   localparam int MEM_LAT    = 2;
   localparam int STARVE_MAX = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, flush, mem_rd, mem_wr;
   logic [31:0] if_addr, mem_addr, mem_wdata;
   logic        if_valid, mem_valid, ram_en, ram_we, stall_pc, stall_mem;
   logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .flush(flush),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .if_valid(if_valid), .if_rdata(if_rdata), .mem_valid(mem_valid),
      .mem_rdata(mem_rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .stall_pc(stall_pc),
      .stall_mem(stall_mem)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] init_word(input int i);
      return (i == 16) ? 32'hDEADBEEF : (32'hCAFE0000 | 32'(i));
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // RAM model: fixed MEM_LAT read pipeline behind the registered command.
   logic [31:0] ram_mem [256];
   logic [31:0] rd_pipe [MEM_LAT];
   bit          ram_ready = 1'b0;
   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < 256; i++) ram_mem[i] <= init_word(i);
         ram_ready <= 1'b1;
      end else if (ram_en && ram_we) begin
         ram_mem[ram_addr[7:0]] <= ram_wdata;
      end
      rd_pipe[0] <= (ram_en && !ram_we) ? ram_mem[ram_addr[7:0]] : 32'h5A5A5A5A;
      for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign ram_rdata = rd_pipe[MEM_LAT-1];

   // Reference model: one access in flight, tracked by the cycle numbers of
   // its command and completion. kind: 0 fetch, 1 load, 2 store.
   logic [31:0] ref_mem [256];
   bit          ref_ready = 1'b0;
   int          s_cmd = -1, s_val = -1, free_at = 0, starve = 0, s_kind = 0;
   bit          s_cancel = 1'b0, s_we = 1'b0;
   logic [31:0] s_addr, s_wdata, s_rdata;
   bit          m_if_v_last = 1'b0, m_mem_v_last = 1'b0;

   always @(negedge clk) begin
      bit e_en, e_ifv, e_memv, mreq;
      if (!ref_ready) begin
         for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
         ref_ready = 1'b1;
      end
      if (rst) begin
         s_cmd = -1; s_val = -1; free_at = 0; starve = 0; s_cancel = 1'b0;
         m_if_v_last = 1'b0; m_mem_v_last = 1'b0;
      end else begin
         mreq   = mem_rd | mem_wr;
         e_en   = (cyc == s_cmd);
         e_memv = (cyc == s_val) && (s_kind != 0);
         e_ifv  = (cyc == s_val) && (s_kind == 0) && !s_cancel && !flush;
         if (s_kind == 0 && flush && cyc >= s_cmd && cyc <= s_val) s_cancel = 1'b1;
         chk("ram_en", ram_en, e_en);
         if (e_en) begin
            chk("ram_we", ram_we, s_we);
            chk("ram_addr", ram_addr, s_addr);
            if (s_we) chk("ram_wdata", ram_wdata, s_wdata);
         end
         chk("if_valid", if_valid, e_ifv);
         chk("mem_valid", mem_valid, e_memv);
         if (e_ifv) chk("if_rdata", if_rdata, s_rdata);
         if (e_memv && s_kind == 1) chk("mem_rdata", mem_rdata, s_rdata);
         chk("stall_pc", stall_pc, if_req && !e_ifv);
         chk("stall_mem", stall_mem, mreq && !e_memv);
         if (cyc >= free_at) begin
            if (!if_req) starve = 0;
            if (mreq && !(if_req && starve == STARVE_MAX)) begin
               s_cmd = cyc + 1; s_val = cyc + 1 + MEM_LAT; free_at = cyc + MEM_LAT + 2;
               s_kind = mem_wr ? 2 : 1; s_we = mem_wr; s_addr = mem_addr;
               s_wdata = mem_wdata; s_cancel = 1'b0;
               if (mem_wr) ref_mem[mem_addr[7:0]] = mem_wdata;
               else        s_rdata = ref_mem[mem_addr[7:0]];
               if (if_req && starve < STARVE_MAX) starve++;
            end else if (if_req && !flush) begin
               s_cmd = cyc + 1; s_val = cyc + 1 + MEM_LAT; free_at = cyc + MEM_LAT + 2;
               s_kind = 0; s_we = 1'b0; s_addr = if_addr; s_cancel = 1'b0;
               s_rdata = ref_mem[if_addr[7:0]];
               starve = 0;
            end
         end
         m_if_v_last  = e_ifv;
         m_mem_v_last = e_memv;
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic run_until_idle();
      int n = 0;
      while ((mem_rd || mem_wr || if_req) && n < 64) begin
         next();
         n++;
         if (m_mem_v_last) begin mem_rd = 1'b0; mem_wr = 1'b0; end
         if (m_if_v_last) if_req = 1'b0;
      end
      chk("drain_bound", (n < 64) ? 1 : 0, 1);
   endtask

   bit flush_last = 1'b0;

   initial begin
      int k;
      rst = 1'b1; if_req = 0; flush = 0; mem_rd = 0; mem_wr = 0;
      if_addr = 0; mem_addr = 0; mem_wdata = 0;
      repeat (3) next();
      chk("rst_ram_en", ram_en, 0);     chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_addr", ram_addr, 0); chk("rst_ram_wdata", ram_wdata, 0);
      chk("rst_if_valid", if_valid, 0); chk("rst_mem_valid", mem_valid, 0);
      chk("rst_if_rdata", if_rdata, 0); chk("rst_mem_rdata", mem_rdata, 0);
      next(); rst = 1'b0;
      next();

      // Lone load of 0x10.
      next(); mem_rd = 1; mem_addr = 32'h10; #2;
      chk("t1_c0_stall_mem", stall_mem, 1); chk("t1_c0_ram_en", ram_en, 0);
      next(); #2;
      chk("t1_c1_ram_en", ram_en, 1); chk("t1_c1_ram_we", ram_we, 0);
      chk("t1_c1_ram_addr", ram_addr, 32'h10); chk("t1_c1_stall_mem", stall_mem, 1);
      next(); #2;
      chk("t1_c2_mem_valid", mem_valid, 0); chk("t1_c2_stall_mem", stall_mem, 1);
      next(); #2;
      chk("t1_c3_mem_valid", mem_valid, 1); chk("t1_c3_mem_rdata", mem_rdata, 32'hDEADBEEF);
      chk("t1_c3_stall_mem", stall_mem, 0);
      next(); mem_rd = 0;

      // Store and fetch arriving together: store first.
      next(); if_req = 1; if_addr = 32'h20; mem_wr = 1; mem_addr = 32'h30;
      mem_wdata = 32'h12345678; #2;
      chk("t2_c0_stall_pc", stall_pc, 1);
      next(); #2;
      chk("t2_c1_ram_en", ram_en, 1); chk("t2_c1_ram_we", ram_we, 1);
      chk("t2_c1_ram_addr", ram_addr, 32'h30); chk("t2_c1_ram_wdata", ram_wdata, 32'h12345678);
      next(); #2; chk("t2_c2_stall_pc", stall_pc, 1);
      next(); #2; chk("t2_c3_mem_valid", mem_valid, 1); chk("t2_c3_stall_pc", stall_pc, 1);
      next(); mem_wr = 0; #2; chk("t2_c4_ram_en", ram_en, 0); chk("t2_c4_stall_pc", stall_pc, 1);
      next(); #2;
      chk("t2_c5_ram_en", ram_en, 1); chk("t2_c5_ram_we", ram_we, 0);
      chk("t2_c5_ram_addr", ram_addr, 32'h20);
      next(); #2; chk("t2_c6_stall_pc", stall_pc, 1);
      next(); #2;
      chk("t2_c7_if_valid", if_valid, 1); chk("t2_c7_if_rdata", if_rdata, 32'hCAFE0020);
      chk("t2_c7_stall_pc", stall_pc, 0);
      next(); if_req = 0;

      // Starvation: three data grants, then fetch forced, then data again.
      next(); if_req = 1; if_addr = 32'h40; mem_rd = 1; mem_addr = 32'h50;
      for (int i = 1; i <= 17; i++) begin
         next();
         if (i == 16) if_addr = 32'h44;
         #2;
         if (i == 1 || i == 5 || i == 9 || i == 17) begin
            chk("t3_data_grant_en", ram_en, 1);
            chk("t3_data_grant_addr", ram_addr, 32'h50);
         end
         if (i == 13) begin
            chk("t3_forced_fetch_en", ram_en, 1);
            chk("t3_forced_fetch_addr", ram_addr, 32'h40);
         end
         if (i == 15) begin
            chk("t3_if_valid", if_valid, 1);
            chk("t3_if_rdata", if_rdata, 32'hCAFE0040);
         end
      end
      run_until_idle();

      // Flush while the fetch is in flight.
      next(); if_req = 1; if_addr = 32'h60;
      next(); #2; chk("t4_c1_ram_en", ram_en, 1); chk("t4_c1_ram_addr", ram_addr, 32'h60);
      next(); flush = 1; #2; chk("t4_c2_if_valid", if_valid, 0);
      next(); flush = 0; if_req = 0; #2; chk("t4_c3_if_valid", if_valid, 0);
      next(); mem_rd = 1; mem_addr = 32'h70;
      next(); #2; chk("t4_c5_ram_en", ram_en, 1); chk("t4_c5_ram_addr", ram_addr, 32'h70);
      run_until_idle();

      // Asynchronous reset in the middle of a load.
      next(); mem_rd = 1; mem_addr = 32'h80;
      next(); #2; chk("t5_c1_ram_en", ram_en, 1);
      next(); #2; rst = 1; #1;
      chk("t5_rst_ram_en", ram_en, 0); chk("t5_rst_mem_valid", mem_valid, 0);
      chk("t5_rst_stall_mem", stall_mem, 1);
      next(); next(); rst = 0; #2;
      chk("t5_r0_ram_en", ram_en, 0);
      next(); #2; chk("t5_r1_ram_en", ram_en, 1); chk("t5_r1_ram_addr", ram_addr, 32'h80);
      next(); #2; chk("t5_r2_mem_valid", mem_valid, 0);
      next(); #2; chk("t5_r3_mem_valid", mem_valid, 1);
      chk("t5_r3_mem_rdata", mem_rdata, 32'hCAFE0080);
      next(); mem_rd = 0;

      // Read and write together behave as a store.
      next(); mem_rd = 1; mem_wr = 1; mem_addr = 32'h90; mem_wdata = 32'h0BADF00D;
      next(); #2;
      chk("t6_ram_en", ram_en, 1); chk("t6_ram_we", ram_we, 1);
      chk("t6_ram_wdata", ram_wdata, 32'h0BADF00D);
      run_until_idle();
      next(); mem_rd = 1; mem_wr = 0; mem_addr = 32'h90;
      next(); next(); next(); #2;
      chk("t6_readback_valid", mem_valid, 1); chk("t6_readback_rdata", mem_rdata, 32'h0BADF00D);
      next(); mem_rd = 0;

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         next();
         if (m_mem_v_last) begin mem_rd = 0; mem_wr = 0; end
         if (m_if_v_last || flush_last) if_req = 0;
         flush = ($urandom_range(15) == 0);
         flush_last = flush;
         if (!(mem_rd || mem_wr) && $urandom_range(2) == 0) begin
            k = $urandom_range(2);
            mem_rd = (k != 1); mem_wr = (k != 0);
            mem_addr = 32'($urandom_range(255)); mem_wdata = $urandom();
         end
         if (!if_req && !flush && $urandom_range(1) == 0) begin
            if_req = 1; if_addr = 32'($urandom_range(255));
         end
      end
      next(); flush = 0;
      if (flush_last) if_req = 0;
      if (m_mem_v_last) begin mem_rd = 0; mem_wr = 0; end
      if (m_if_v_last) if_req = 0;
      run_until_idle();
      next(); next();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
